// File: rtl/sv_bus_mux_demux_demux.sv
// Receive side of the bus-to-byte-stream link.
// Collects 8-byte packets from the stream and rebuilds one {adr, dat} bus write.
// The assembly register fills while the output register holds the previous
// packet. This lets a full-rate stream continue while the bus side drains.
module sv_bus_mux_demux_demux (
  input  logic        clk,
  input  logic        rst,
  input  logic        str_vld,
  input  logic [7:0]  str_bus,
  output logic        str_rdy,
  output logic        bus_vld,
  output logic [31:0] bus_adr,
  output logic [31:0] bus_dat,
  input  logic        bus_rdy
);

  // Bus view overlaid on the byte view.
  // str[0] is the dat LSB and str[7] is the adr MSB, which matches the transmit order.
  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
  } t_bus;

  typedef union packed {
    t_bus            bus;
    logic [7:0][7:0] str;
  } t_uni;

  logic [2:0] cnt;
  t_uni       asm_q;
  t_uni       out_q;
  t_uni       ld_val;
  logic       vld_q;
  logic       str_trn;
  logic       bus_trn;
  logic       load;

  // Only the last byte can stall, and only when the output slot is still full.
  // Bytes 0..6 land in the assembly register, which is always free.
  assign str_rdy = ~((cnt == 3'd7) & vld_q & ~bus_rdy);
  assign str_trn = str_vld & str_rdy;
  assign bus_trn = vld_q & bus_rdy;
  assign load    = str_trn & (cnt == 3'd7);

  // Load value: the seven assembled bytes plus the byte arriving now.
  always_comb begin
    ld_val        = asm_q;
    ld_val.str[7] = str_bus;
  end

  // Byte counter, assembly bytes, output register and bus valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= 3'd0;
      asm_q <= '0;
      out_q <= '0;
      vld_q <= 1'b0;
    end else begin
      if (str_trn) begin
        asm_q.str[cnt] <= str_bus;
        cnt            <= cnt + 3'd1;
      end
      // A load in the same cycle as a drain replaces the packet without a bubble.
      if (load) begin
        out_q <= ld_val;
        vld_q <= 1'b1;
      end else if (bus_trn) begin
        vld_q <= 1'b0;
      end
    end
  end

  assign bus_vld = vld_q;
  assign bus_adr = out_q.bus.adr;
  assign bus_dat = out_q.bus.dat;

endmodule

// File: tb/tb_sv_bus_mux_demux_demux.sv
// Directed bench for the byte-stream to bus demux.
module tb_sv_bus_mux_demux_demux;

  logic        clk = 1'b0;
  logic        rst;
  logic        str_vld;
  logic [7:0]  str_bus;
  logic        str_rdy;
  logic        bus_vld;
  logic [31:0] bus_adr;
  logic [31:0] bus_dat;
  logic        bus_rdy;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int n_stall = 0;
  bit mon_en = 1'b0;
  bit rnd_en = 1'b0;
  logic [63:0] got_q[$];
  int          stamp_q[$];
  logic [63:0] exp_q[$];

  sv_bus_mux_demux_demux dut (
    .clk     (clk),
    .rst     (rst),
    .str_vld (str_vld),
    .str_bus (str_bus),
    .str_rdy (str_rdy),
    .bus_vld (bus_vld),
    .bus_adr (bus_adr),
    .bus_dat (bus_dat),
    .bus_rdy (bus_rdy)
  );

  always #5 clk = ~clk;

  // Mid-cycle monitor: inputs change at posedge+1, so vld & rdy here means
  // a bus transfer happens at the coming posedge.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (mon_en) begin
      if (bus_vld && bus_rdy) begin
        got_q.push_back({bus_adr, bus_dat});
        stamp_q.push_back(cyc);
      end
      if (!str_rdy) n_stall <= n_stall + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_en) bus_rdy = 1'($urandom_range(0, 1));
  endtask

  // Offer one byte and hold it until accepted.
  // Returns at posedge+1 right after the accepting edge.
  task automatic put(input logic [7:0] b);
    int n;
    n = 0;
    str_vld = 1'b1;
    str_bus = b;
    forever begin
      @(negedge clk);
      if (str_rdy) break;
      tick();
      n++;
      if (n > 64) begin
        chk("put_timeout", 64'(n), 64'd0);
        break;
      end
    end
    tick();
    str_vld = 1'b0;
  endtask

  task automatic send_pkt(input logic [31:0] adr, input logic [31:0] dat,
                          input int gap_at, input int gap_len, input bit rnd_gap);
    logic [63:0] w;
    w = {adr, dat};
    for (int k = 0; k < 8; k++) begin
      if (k == gap_at) repeat (gap_len) tick();
      if (rnd_gap) repeat ($urandom_range(0, 2)) tick();
      put(w[8*k +: 8]);
    end
  endtask

  initial begin
    logic [31:0] a, d;
    rst = 1'b1; str_vld = 1'b0; str_bus = 8'h00; bus_rdy = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_vld", 64'(bus_vld), 64'd0);
    chk("rst_adr_dat", {bus_adr, bus_dat}, 64'd0);
    chk("rst_str_rdy", 64'(str_rdy), 64'd1);

    // Single packet, bytes 0x11..0x88.
    send_pkt(32'h88776655, 32'h44332211, -1, 0, 1'b0);
    chk("single_vld", 64'(bus_vld), 64'd1);
    chk("single_dat", 64'(bus_dat), 64'h44332211);
    chk("single_adr", 64'(bus_adr), 64'h88776655);
    tick();
    chk("single_vld_clr", 64'(bus_vld), 64'd0);

    // Same packet with 3 idle cycles between bytes 2 and 3.
    send_pkt(32'h88776655, 32'h44332211, 3, 3, 1'b0);
    chk("gap_vld", 64'(bus_vld), 64'd1);
    chk("gap_adr_dat", {bus_adr, bus_dat}, 64'h88776655_44332211);
    tick();

    // Output backpressure.
    bus_rdy = 1'b0;
    send_pkt(32'hA7A6A5A4, 32'hA3A2A1A0, -1, 0, 1'b0);
    chk("bp_a_vld", 64'(bus_vld), 64'd1);
    for (int k = 0; k < 7; k++) put(8'hB0 + 8'(k));
    str_vld = 1'b1; str_bus = 8'hB7;
    @(negedge clk);
    chk("bp_stall", 64'(str_rdy), 64'd0);
    chk("bp_hold_a", {bus_adr, bus_dat}, 64'hA7A6A5A4_A3A2A1A0);
    tick();
    @(negedge clk);
    chk("bp_stall2", 64'(str_rdy), 64'd0);
    chk("bp_hold_a2", {bus_adr, bus_dat}, 64'hA7A6A5A4_A3A2A1A0);
    tick();
    bus_rdy = 1'b1;
    @(negedge clk);
    chk("bp_release", 64'(str_rdy), 64'd1);
    tick();
    str_vld = 1'b0;
    chk("bp_b_vld", 64'(bus_vld), 64'd1);
    chk("bp_b_data", {bus_adr, bus_dat}, 64'hB7B6B5B4_B3B2B1B0);
    tick();
    chk("bp_b_drained", 64'(bus_vld), 64'd0);

    // Back-to-back full rate.
    got_q.delete(); stamp_q.delete(); n_stall = 0;
    mon_en = 1'b1;
    for (int i = 0; i < 4; i++) send_pkt(32'h1000_0000 + i, 32'hCAFE_0000 + i, -1, 0, 1'b0);
    repeat (2) tick();
    mon_en = 1'b0;
    chk("b2b_count", 64'(got_q.size()), 64'd4);
    chk("b2b_no_stall", 64'(n_stall), 64'd0);
    if (got_q.size() == 4) begin
      for (int i = 0; i < 4; i++)
        chk($sformatf("b2b_pkt%0d", i), got_q[i], {32'h1000_0000 + i, 32'hCAFE_0000 + i});
      for (int i = 1; i < 4; i++)
        chk($sformatf("b2b_gap%0d", i), 64'(stamp_q[i] - stamp_q[i-1]), 64'd8);
    end

    // Reset mid-packet with a packet pending on the bus side.
    bus_rdy = 1'b0;
    send_pkt(32'hDEADBEEF, 32'h0BADF00D, -1, 0, 1'b0);
    for (int k = 0; k < 5; k++) put(8'hE0 + 8'(k));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_vld", 64'(bus_vld), 64'd0);
    chk("mid_rst_adr_dat", {bus_adr, bus_dat}, 64'd0);
    bus_rdy = 1'b1;
    send_pkt(32'h08070605, 32'h04030201, -1, 0, 1'b0);
    chk("post_rst_vld", 64'(bus_vld), 64'd1);
    chk("post_rst_data", {bus_adr, bus_dat}, 64'h08070605_04030201);
    tick();

    // Random stream gaps and random bus stalls against a scoreboard.
    got_q.delete(); exp_q.delete();
    mon_en = 1'b1;
    rnd_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a = $urandom; d = $urandom;
      exp_q.push_back({a, d});
      send_pkt(a, d, -1, 0, 1'b1);
    end
    rnd_en = 1'b0;
    bus_rdy = 1'b1;
    repeat (4) tick();
    mon_en = 1'b0;
    chk("rnd_count", 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("rnd_pkt%0d", i), got_q[i], exp_q[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Guard against a hang anywhere above.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
